// File: rtl/tsnperf_frame_gen_pkg.sv
// rtl/tsnperf_frame_gen_pkg.sv - shared TSNPerf frame definitions (states, header offsets, defaults)
package tsnperf_frame_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  localparam int SEQ_OFF = 14;
  localparam int TS_OFF  = 18;
  localparam int HDR_LEN = 26;

  localparam logic [47:0] DST_MAC_DEF   = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC_MAC_DEF   = 48'h0002_0304_0506;
  localparam logic [15:0] ETHERTYPE_DEF = 16'h88B5;
  localparam int          MIN_LEN_DEF   = 60;
  localparam int          MAX_LEN_DEF   = 1514;

  function automatic logic [10:0] clamp_len(input logic [10:0] len, input int lo, input int hi);
    if (len < 11'(lo)) return 11'(lo);
    if (len > 11'(hi)) return 11'(hi);
    return len;
  endfunction

endpackage

// File: rtl/tsnperf_hdr_mux.sv
// rtl/tsnperf_hdr_mux.sv - combinational header byte select by byte index
module tsnperf_hdr_mux
  import tsnperf_frame_gen_pkg::*;
#(
  parameter logic [47:0] DST_MAC   = DST_MAC_DEF,
  parameter logic [47:0] SRC_MAC   = SRC_MAC_DEF,
  parameter logic [15:0] ETHERTYPE = ETHERTYPE_DEF
) (
  input  logic [10:0] idx,
  input  logic [31:0] seq,
  input  logic [63:0] ts,
  output logic [7:0]  hdr_byte
);

  // Byte 0 sits in the top octet; seq lands at SEQ_OFF and ts at TS_OFF.
  logic [HDR_LEN*8-1:0] hdr;
  assign hdr = {DST_MAC, SRC_MAC, ETHERTYPE, seq, ts};

  always_comb begin
    hdr_byte = 8'h00;
    for (int i = 0; i < HDR_LEN; i++) begin
      if (idx == 11'(i)) hdr_byte = hdr[(HDR_LEN-1-i)*8 +: 8];
    end
  end

endmodule

// File: rtl/tsnperf_frame_gen.sv
// rtl/tsnperf_frame_gen.sv - TSNPerf test-frame source driving the MAC TX FIFO AXI-S port
module tsnperf_frame_gen
  import tsnperf_frame_gen_pkg::*;
#(
  parameter logic [47:0] DST_MAC   = DST_MAC_DEF,
  parameter logic [47:0] SRC_MAC   = SRC_MAC_DEF,
  parameter logic [15:0] ETHERTYPE = ETHERTYPE_DEF,
  parameter int          MIN_LEN   = MIN_LEN_DEF,
  parameter int          MAX_LEN   = MAX_LEN_DEF
) (
  input  logic        tx_fifo_clock,
  input  logic        tx_fifo_reset,
  input  logic        start,
  input  logic        stop,
  input  logic [10:0] cfg_len,
  input  logic [31:0] cfg_count,
  input  logic [15:0] cfg_gap,
  input  logic [63:0] timestamp,
  output logic [7:0]  tx_axis_tdata,
  output logic        tx_axis_tvalid,
  input  logic        tx_axis_tready,
  output logic        tx_axis_tlast,
  output logic        busy,
  output logic [31:0] frames_sent
);

  state_t      state;
  logic [10:0] idx;
  logic [10:0] len_q;
  logic [31:0] count_q;
  logic [15:0] gap_q;
  logic [15:0] gap_cnt;
  logic [31:0] seq;
  logic [63:0] ts_q;
  logic        stop_seen;

  logic [10:0] idx_nx;
  logic [7:0]  hdr_byte;
  logic [7:0]  next_byte;
  logic        hs;
  logic        last_beat;
  logic        end_run;

  assign idx_nx    = idx + 11'd1;
  assign hs        = tx_axis_tvalid & tx_axis_tready;
  assign last_beat = (idx == len_q - 11'd1);
  assign end_run   = stop_seen | stop |
                     ((count_q != 32'd0) && (frames_sent + 32'd1 == count_q));
  assign next_byte = (idx_nx < 11'(HDR_LEN)) ? hdr_byte : idx_nx[7:0];

  tsnperf_hdr_mux #(
    .DST_MAC  (DST_MAC),
    .SRC_MAC  (SRC_MAC),
    .ETHERTYPE(ETHERTYPE)
  ) u_hdr_mux (
    .idx     (idx_nx),
    .seq     (seq),
    .ts      (ts_q),
    .hdr_byte(hdr_byte)
  );

  // Entering HDR always presents byte 0 and latches the launch timestamp on the same edge.
  always_ff @(posedge tx_fifo_clock) begin
    if (tx_fifo_reset) begin
      state          <= ST_IDLE;
      idx            <= '0;
      len_q          <= 11'(MIN_LEN);
      count_q        <= '0;
      gap_q          <= '0;
      gap_cnt        <= '0;
      seq            <= '0;
      ts_q           <= '0;
      stop_seen      <= 1'b0;
      tx_axis_tdata  <= '0;
      tx_axis_tvalid <= 1'b0;
      tx_axis_tlast  <= 1'b0;
      busy           <= 1'b0;
      frames_sent    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q          <= clamp_len(cfg_len, MIN_LEN, MAX_LEN);
            count_q        <= cfg_count;
            gap_q          <= cfg_gap;
            seq            <= '0;
            frames_sent    <= '0;
            stop_seen      <= 1'b0;
            state          <= ST_HDR;
            idx            <= '0;
            ts_q           <= timestamp;
            tx_axis_tdata  <= DST_MAC[47:40];
            tx_axis_tvalid <= 1'b1;
            tx_axis_tlast  <= 1'b0;
            busy           <= 1'b1;
          end
        end

        ST_HDR, ST_PAYLOAD: begin
          if (stop) stop_seen <= 1'b1;
          if (hs) begin
            if (last_beat) begin
              frames_sent   <= frames_sent + 32'd1;
              seq           <= seq + 32'd1;
              stop_seen     <= 1'b0;
              tx_axis_tlast <= 1'b0;
              idx           <= '0;
              if (end_run) begin
                state          <= ST_IDLE;
                tx_axis_tvalid <= 1'b0;
                tx_axis_tdata  <= '0;
                busy           <= 1'b0;
              end else if (gap_q != 16'd0) begin
                state          <= ST_GAP;
                gap_cnt        <= gap_q - 16'd1;
                tx_axis_tvalid <= 1'b0;
                tx_axis_tdata  <= '0;
              end else begin
                state         <= ST_HDR;
                ts_q          <= timestamp;
                tx_axis_tdata <= DST_MAC[47:40];
              end
            end else begin
              idx           <= idx_nx;
              tx_axis_tdata <= next_byte;
              tx_axis_tlast <= (idx_nx == len_q - 11'd1);
              if (idx == 11'(HDR_LEN - 1)) state <= ST_PAYLOAD;
            end
          end
        end

        ST_GAP: begin
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (gap_cnt == 16'd0) begin
            state          <= ST_HDR;
            idx            <= '0;
            ts_q           <= timestamp;
            tx_axis_tdata  <= DST_MAC[47:40];
            tx_axis_tvalid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tsnperf_frame_gen.sv
// tb/tb_tsnperf_frame_gen.sv - scoreboard bench for tsnperf_frame_gen
module tb_tsnperf_frame_gen;

  localparam logic [63:0] TS_C = 64'h0123_4567_89AB_CDEF;
  localparam logic [47:0] DST  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC  = 48'h0002_0304_0506;
  localparam int          BUDGET = 20000;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [10:0] cfg_len = 11'd60;
  logic [31:0] cfg_count = 32'd1;
  logic [15:0] cfg_gap = 16'd0;
  logic [63:0] timestamp = TS_C;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        tlast;
  logic        busy;
  logic [31:0] frames_sent;

  int    n_chk = 0;
  int    n_fail = 0;
  beat_t sb[$];
  beat_t exp_b;
  beat_t prev;
  bit    prev_stall = 0;
  int    frm = 0;
  int    bidx = 0;
  int    last_len = 0;
  logic [7:0] cap [0:1513];
  bit    in_gap = 0;
  bit    gap_chk = 0;
  int    idle_cnt = 0;
  int    exp_gap = 0;
  bit    rnd_ready = 0;
  logic  ready_force = 1'b1;
  bit    ts_ramp = 0;
  logic [63:0] ts_at;

  tsnperf_frame_gen dut (
    .tx_fifo_clock (clk),
    .tx_fifo_reset (rst),
    .start         (start),
    .stop          (stop),
    .cfg_len       (cfg_len),
    .cfg_count     (cfg_count),
    .cfg_gap       (cfg_gap),
    .timestamp     (timestamp),
    .tx_axis_tdata (tdata),
    .tx_axis_tvalid(tvalid),
    .tx_axis_tready(tready),
    .tx_axis_tlast (tlast),
    .busy          (busy),
    .frames_sent   (frames_sent)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input int len, input logic [31:0] seq, input logic [63:0] ts);
    logic [207:0] h;
    beat_t b;
    h = {DST, SRC, 16'h88B5, seq, ts};
    for (int i = 0; i < len; i++) begin
      b.last = (i == len - 1);
      b.data = (i < 26) ? h[207-8*i -: 8] : 8'(i);
      sb.push_back(b);
    end
  endtask

  always @(posedge clk) begin
    #1;
    tready    = rnd_ready ? 1'($urandom_range(0, 1)) : ready_force;
    timestamp = ts_ramp ? timestamp + 64'd1 : TS_C;
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
      in_gap     = 0;
    end else begin
      if (prev_stall)
        check_eq("hold", 64'({tvalid, tlast, tdata}), 64'({1'b1, prev.last, prev.data}));
      prev_stall = tvalid && !tready;
      prev.last  = tlast;
      prev.data  = tdata;
      if (in_gap) begin
        if (!tvalid) idle_cnt++;
        else begin
          if (gap_chk) check_eq("gap", 64'(idle_cnt), 64'(exp_gap));
          in_gap = 0;
        end
      end
      if (tvalid && tready) begin
        if (sb.size() == 0) check_eq("extra_beat", 64'(1), 64'(0));
        else begin
          exp_b = sb.pop_front();
          check_eq("beat", 64'({tlast, tdata}), 64'({exp_b.last, exp_b.data}));
        end
        if (bidx < 1514) cap[bidx] = tdata;
        bidx++;
        if (tlast) begin
          last_len = bidx;
          bidx     = 0;
          frm++;
          in_gap   = 1;
          idle_cnt = 0;
        end
      end
    end
  end

  task automatic run_start(input int len_cfg, input int cnt, input int gap, input int exp_len,
                           input int nfr);
    frm    = 0;
    bidx   = 0;
    in_gap = 0;
    @(negedge clk);
    cfg_len   = 11'(len_cfg);
    cfg_count = 32'(cnt);
    cfg_gap   = 16'(gap);
    start     = 1'b1;
    ts_at     = timestamp;
    for (int f = 0; f < nfr; f++) push_frame(exp_len, 32'(f), ts_at);
    @(negedge clk);
    start     = 1'b0;
    cfg_len   = 11'd100;
    cfg_count = 32'd7;
    cfg_gap   = 16'd9;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 64'(busy), 64'(0));
    repeat (2) @(negedge clk);
    check_eq({tag, "_sb_empty"}, 64'(sb.size()), 64'(0));
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_eq("rst_tvalid", 64'(tvalid), 64'(0));
    check_eq("rst_tlast", 64'(tlast), 64'(0));
    check_eq("rst_tdata", 64'(tdata), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_frames", 64'(frames_sent), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    run_start(60, 1, 0, 60, 1);
    wait_idle("t1_idle");
    check_eq("t1_frames", 64'(frames_sent), 64'(1));
    check_eq("t1_len", 64'(last_len), 64'(60));
    check_eq("t1_type", 64'({cap[12], cap[13]}), 64'h88B5);
    check_eq("t1_seq", 64'({cap[14], cap[15], cap[16], cap[17]}), 64'(0));

    run_start(20, 1, 0, 60, 1);
    wait_idle("t2a_idle");
    check_eq("t2a_len", 64'(last_len), 64'(60));
    run_start(2000, 1, 0, 1514, 1);
    wait_idle("t2b_idle");
    check_eq("t2b_len", 64'(last_len), 64'(1514));

    rnd_ready = 1;
    gap_chk   = 1;
    exp_gap   = 5;
    run_start(64, 3, 5, 64, 3);
    wait_idle("t3_idle");
    check_eq("t3_frames", 64'(frames_sent), 64'(3));
    rnd_ready = 0;
    exp_gap   = 2;

    run_start(60, 0, 2, 60, 5);
    n = 0;
    while (!(frm == 4 && bidx >= 30) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check_eq("t4_reach_stop_point", 64'(frm), 64'(4));
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_idle("t4_idle");
    repeat (20) @(negedge clk);
    check_eq("t4_frames", 64'(frames_sent), 64'(5));
    check_eq("t4_mon_frames", 64'(frm), 64'(5));
    check_eq("t4_tvalid", 64'(tvalid), 64'(0));
    gap_chk = 0;

    run_start(100, 1, 0, 100, 1);
    n = 0;
    while (bidx < 40 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5_tvalid", 64'(tvalid), 64'(0));
    check_eq("t5_busy", 64'(busy), 64'(0));
    check_eq("t5_frames", 64'(frames_sent), 64'(0));
    rst = 1'b0;
    sb.delete();
    run_start(60, 1, 0, 60, 1);
    wait_idle("t5_idle");
    check_eq("t5_seq", 64'({cap[14], cap[15], cap[16], cap[17]}), 64'(0));

    ts_ramp     = 1;
    ready_force = 1'b0;
    @(negedge clk);
    run_start(60, 1, 0, 60, 1);
    repeat (10) @(negedge clk);
    ready_force = 1'b1;
    wait_idle("t6_idle");
    check_eq("t6_ts", {cap[18], cap[19], cap[20], cap[21], cap[22], cap[23], cap[24], cap[25]},
             ts_at);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
